hilo_div_sequencer: RTL and testbench

Multi-cycle divider sequencer for the HILO path of the 5-stage MIPS pipeline. Accepts a DIV/DIVU operation from the EX stage and runs a radix-2 restoring divide over WIDTH cycles. Holds the pipeline stalled while busy, then presents quotient/remainder with a one-cycle HILO write strobe. Sits beside the ALU in EX; its stall output is ORed into the hazard unit's StallE/StallD.

---
 rtl/hilo_div_sequencer_pkg.sv | 14 +
 rtl/hilo_div_sequencer_div_step.sv | 34 +++
 rtl/hilo_div_sequencer.sv | 128 ++++++++++++
 tb/tb_hilo_div_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_sequencer_pkg.sv
// Shared definitions for the HILO divide sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package hilo_div_sequencer_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/hilo_div_sequencer_div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer decides when the result is captured.
module hilo_div_sequencer_div_step
    import hilo_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    // Partial remainder is one bit wider than the operands so the shifted-in
    // bit can never overflow the compare/subtract.
    logic [WIDTH:0] partial;
    logic [WIDTH:0] trial;

    // Shift {rem,quo} left, try the subtraction, keep it only when it does not borrow.
    always_comb begin
        partial = {remIn, quoIn[WIDTH-1]};
        trial   = partial - {1'b0, divisor};
        if (trial[WIDTH]) begin
            remOut = partial[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end else begin
            remOut = trial[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/hilo_div_sequencer.sv
// DIV/DIVU sequencer for the HILO path: restoring divide, one bit per cycle.
// Latency: WIDTH+1 cycles start->done, 1 cycle for divide-by-zero.
// Backpressure: stall holds IF/ID/EX while busy; cancel (FlushE) aborts at once.
module hilo_div_sequencer
    import hilo_div_sequencer_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    divState_t        state;
    logic [CNT_W-1:0] stepCount;
    logic [WIDTH-1:0] remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divisorReg;
    logic             negQuo;
    logic             negRem;
    logic             doneReg;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] loFinal;
    logic [WIDTH-1:0] hiFinal;

    hilo_div_sequencer_div_step #(
        .WIDTH (WIDTH)
    ) stepUnit (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorReg),
        .remOut  (remNext),
        .quoOut  (quoNext)
    );

    // Operand magnitudes; the most negative value maps onto itself, which is
    // exactly its magnitude when read as unsigned.
    always_comb begin
        absA = (sign && a[WIDTH-1]) ? -a : a;
        absB = (sign && b[WIDTH-1]) ? -b : b;
    end

    // Sign fix-up applied to the last iteration's result as it is written to HILO.
    always_comb begin
        loFinal = negQuo ? -quoNext : quoNext;
        hiFinal = negRem ? -remNext : remNext;
    end

    // Stall covers the launch cycle and every RUN cycle; a flush always releases it.
    assign stall = ~cancel & (((state == IDLE) & start) | (state == RUN));
    assign done  = doneReg & ~cancel;

    // Sequencer FSM: launch, iterate, publish results for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stepCount  <= '0;
            remReg     <= '0;
            quoReg     <= '0;
            divisorReg <= '0;
            negQuo     <= 1'b0;
            negRem     <= 1'b0;
            doneReg    <= 1'b0;
            lo         <= '0;
            hi         <= '0;
        end else begin
            doneReg <= 1'b0;
            if (cancel) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (b == '0) begin
                                lo      <= '1;
                                hi      <= a;
                                doneReg <= 1'b1;
                                state   <= DONE;
                            end else begin
                                remReg     <= '0;
                                quoReg     <= absA;
                                divisorReg <= absB;
                                negQuo     <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                                negRem     <= sign & a[WIDTH-1];
                                stepCount  <= LAST_STEP;
                                state      <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        remReg    <= remNext;
                        quoReg    <= quoNext;
                        stepCount <= stepCount - CNT_W'(1);
                        if (stepCount == '0) begin
                            lo      <= loFinal;
                            hi      <= hiFinal;
                            doneReg <= 1'b1;
                            state   <= DONE;
                        end
                    end
                    DONE: begin
                        // The retiring instruction may still hold start high here.
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_sequencer.sv
module tb_hilo_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic        cancel;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        done;
    logic [31:0] lo;
    logic [31:0] hi;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          cyc;
    } expT;

    expT         expQ[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastLo = 32'h0;
    logic [31:0] lastHi = 32'h0;

    hilo_div_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sign   (sign),
        .cancel (cancel),
        .a      (a),
        .b      (b),
        .stall  (stall),
        .done   (done),
        .lo     (lo),
        .hi     (hi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // MIPS DIV/DIVU semantics from plain arithmetic.
    function automatic void refDiv(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                   output logic [31:0] q, output logic [31:0] r);
        if (bv == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = av;
        end else if (sv) begin
            if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'h0;
            end else begin
                q = $signed(av) / $signed(bv);
                r = $signed(av) % $signed(bv);
            end
        end else begin
            q = av / bv;
            r = av % bv;
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expT e;
        #2;
        if (!rst && done === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_done", {31'h0, done}, 32'h0);
            end else begin
                e = expQ.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("lo", lo, e.lo);
                check("hi", hi, e.hi);
            end
        end
    end

    // Launch at the current negedge; start stays high through DONE like a held instruction.
    task automatic doOp(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        logic [31:0] q;
        logic [31:0] r;
        int          n;
        int          lat;
        expT         e;
        refDiv(av, bv, sv, q, r);
        lat = (bv == 32'h0) ? 1 : 33;
        n = cyc;
        start = 1'b1;
        a = av;
        b = bv;
        sign = sv;
        e.lo = q;
        e.hi = r;
        e.cyc = n + lat;
        expQ.push_back(e);
        #1;
        check("stall_launch", {31'h0, stall}, 32'h1);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
            #1;
            if (c < lat) begin
                check("stall_busy", {31'h0, stall}, 32'h1);
                check("lo_hold", lo, lastLo);
                check("hi_hold", hi, lastHi);
            end else begin
                check("stall_done", {31'h0, stall}, 32'h0);
            end
        end
        lastLo = q;
        lastHi = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1;
        start = 1'b0;
        sign = 1'b0;
        cancel = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_hi", hi, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the divider's corner list.
        doOp(32'd100, 32'd7, 1'b0);
        doOp(32'hFFFF_FFF9, 32'd2, 1'b1);
        doOp(32'hFFFF_FFF9, 32'd2, 1'b0);
        doOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        doOp(32'h0000_1234, 32'h0, 1'b0);
        doOp(32'd7, 32'hFFFF_FFFE, 1'b1);
        // Back-to-back: second launch the cycle after DONE.
        doOp(32'd100, 32'd7, 1'b1);
        doOp(32'd45, 32'd4, 1'b1);

        // Flush mid-RUN: no done, stall released, HILO untouched.
        start = 1'b1; a = 32'd100; b = 32'd7; sign = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
        end
        cancel = 1'b1;
        #1;
        check("stall_cancel", {31'h0, stall}, 32'h0);
        @(negedge clk);
        cancel = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            check("cancel_stall_idle", {31'h0, stall}, 32'h0);
            check("cancel_no_done", {31'h0, done}, 32'h0);
            @(negedge clk);
        end
        check("cancel_lo_kept", lo, lastLo);
        check("cancel_hi_kept", hi, lastHi);

        // Start and cancel together in IDLE: nothing launches.
        start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd0;
        #1;
        check("start_cancel_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        repeat (3) begin
            #1;
            check("start_cancel_no_done", {31'h0, done}, 32'h0);
            @(negedge clk);
        end

        // Randomised operands, biased toward interesting divisors.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'h0;
                3: rb = -$urandom_range(1, 15);
                default: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            endcase
            doOp(ra, rb, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of RUN returns everything to reset values.
        start = 1'b1; a = 32'd1000; b = 32'd3; sign = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        #1;
        check("rstrun_stall", {31'h0, stall}, 32'h0);
        check("rstrun_done", {31'h0, done}, 32'h0);
        check("rstrun_lo", lo, 32'h0);
        check("rstrun_hi", hi, 32'h0);
        rst = 1'b0;
        lastLo = 32'h0;
        lastHi = 32'h0;
        @(negedge clk);
        doOp(32'd45, 32'd4, 1'b0);

        repeat (5) @(negedge clk);
        check("queue_empty", expQ.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
